// File: rtl/aqp_hc_debounce.sv
// Hand controller debouncer: 2-flop synchronizer, prescaled sample tick and a
// per-bit run-length filter for both 8-bit controllers, with registered change strobes.
module aqp_hc_debounce #(
  parameter int unsigned TICK_DIV     = 2864,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bypass,
  input  logic [7:0] hc1_raw,
  input  logic [7:0] hc2_raw,
  output logic [7:0] hc1_in,
  output logic [7:0] hc2_in,
  output logic       hc1_changed,
  output logic       hc2_changed
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  // Bits [7:0] belong to controller 1, bits [15:8] to controller 2.
  logic [15:0]   sync1;
  logic [15:0]   sync2;
  logic [15:0]   out_q;
  logic [15:0]   out_d;
  logic [PW-1:0] pre;
  logic          tick;
  logic [CW-1:0] cnt_q [16];
  logic [CW-1:0] cnt_d [16];

  assign tick = (pre == PRE_LAST);

  always_comb begin
    out_d = out_q;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bypass) begin
        out_d[i] = sync2[i];
        cnt_d[i] = '0;
      end else if (tick) begin
        if (sync2[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = sync2[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Strobes compare next against current so they rise with the new output value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '1;
      sync2       <= '1;
      pre         <= '0;
      out_q       <= '1;
      hc1_changed <= 1'b0;
      hc2_changed <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1       <= {hc2_raw, hc1_raw};
      sync2       <= sync1;
      pre         <= tick ? '0 : pre + 1'b1;
      out_q       <= out_d;
      hc1_changed <= (out_d[7:0]  != out_q[7:0]);
      hc2_changed <= (out_d[15:8] != out_q[15:8]);
      cnt_q       <= cnt_d;
    end
  end

  assign hc1_in = out_q[7:0];
  assign hc2_in = out_q[15:8];

endmodule
